mem_bus_arbiter: RTL

//  Shares the single valid/ready memory bus (BRAM + MMIO decode) between two requesters.
//  - Port m0: the CPU.
//  - Port m1: a second master (boot loader / debug DMA).

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between two masters,
// with a per-transaction watchdog that force-completes unacknowledged requests.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        timeout_err,
    output logic [31:0] err_addr,
    input  logic        err_clear
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              err_flag;
    logic [31:0]       err_addr_q;
    logic              own_valid;
    logic              own_done;
    logic              own_timeout;

    // Owner's request status: completion by slave or by the watchdog
    always_comb begin
        own_valid = 1'b0;
        case (state)
            GRANT0:  own_valid = m0_valid;
            GRANT1:  own_valid = m1_valid;
            default: own_valid = 1'b0;
        endcase
        own_done    = own_valid & s_ready;
        own_timeout = own_valid & ~s_ready & (cnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: round-robin arbitration in IDLE, release on done/timeout/abandon
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_valid && !m1_valid)      state_nxt = GRANT0;
                else if (m1_valid && !m0_valid) state_nxt = GRANT1;
                else if (m0_valid && m1_valid)  state_nxt = last_grant ? GRANT0 : GRANT1;
            end
            GRANT0, GRANT1: begin
                if (!own_valid || own_done || own_timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remember the most recent grantee for tie-breaking
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE) begin
            if (state_nxt == GRANT0)      last_grant <= 1'b0;
            else if (state_nxt == GRANT1) last_grant <= 1'b1;
        end
    end

    // Watchdog counter: cleared while idle, saturating count of unacknowledged grant cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (!s_ready && cnt < CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag and address capture; a new timeout beats err_clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag   <= 1'b0;
            err_addr_q <= '0;
        end else if (own_timeout) begin
            err_flag   <= 1'b1;
            err_addr_q <= s_addr;
        end else if (err_clear) begin
            err_flag   <= 1'b0;
        end
    end

    // Output steering: owner's fields to the slave, slave response to the owner only
    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        err_addr    = '0;
        if (!reset) begin
            timeout_err = err_flag;
            err_addr    = err_addr_q;
            case (state)
                GRANT0: begin
                    s_valid  = m0_valid;
                    s_instr  = m0_instr;
                    s_addr   = m0_addr;
                    s_wdata  = m0_wdata;
                    s_wstrb  = m0_wstrb;
                    m0_ready = own_done | own_timeout;
                    m0_rdata = own_timeout ? ERR_RDATA : s_rdata;
                end
                GRANT1: begin
                    s_valid  = m1_valid;
                    s_instr  = m1_instr;
                    s_addr   = m1_addr;
                    s_wdata  = m1_wdata;
                    s_wstrb  = m1_wstrb;
                    m1_ready = own_done | own_timeout;
                    m1_rdata = own_timeout ? ERR_RDATA : s_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
